// File: rtl/dcache_pkg.sv
// Shared definitions for the blocking write-through data cache controller.
// Holds the default geometry, the derived widths and the controller FSM
// state encoding. Imported by the controller top and its data array.
package dcache_pkg;

  // Default geometry: 32-bit byte addresses, 16 lines of 4 words (16 B).
  localparam int DC_ADDR_W     = 32;
  localparam int DC_INDEX_BITS = 4;
  localparam int DC_WOFF_BITS  = 2;

  // Derived widths for the default geometry. The two low address bits
  // select a byte inside a word and never reach the cache.
  localparam int TAG_W = DC_ADDR_W - DC_INDEX_BITS - DC_WOFF_BITS - 2;
  localparam int LINES = 1 << DC_INDEX_BITS;
  localparam int WORDS = 1 << DC_WOFF_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // serve hits, detect misses and stores
    RREQ  = 3'd1,  // line read request on the bus
    RDATA = 3'd2,  // collecting refill beats
    WREQ  = 3'd3,  // single-word write request on the bus
    DONE  = 3'd4   // store retired; pipeline advances this cycle
  } state_t;

endpackage

// File: rtl/dcache_stall_ctrl_if.sv
// Bus bundles for the data cache controller.
//
// dcache_cpu_if : pipeline (master) <-> cache (slave)
//   cpu_re, cpu_wbyteen, cpu_addr, cpu_wdata : request from the EX/WB stage
//   cpu_rdata, stall                         : combinational replies
//
// dcache_mem_if : cache (master) <-> memory (slave)
//   mem_req, mem_we, mem_addr, mem_wdata, mem_byteen : registered request
//   mem_ack, mem_rvalid, mem_rdata                   : memory responses
//
// Memory handshake: the cache raises mem_req with stable mem_we/addr/wdata/
// byteen and holds them until a cycle in which mem_ack is high; the request
// is accepted on that rising edge and mem_req drops the next cycle. mem_ack
// while mem_req is low means nothing. A line read then returns 2^WOFF_BITS
// beats on mem_rvalid, in address order, with arbitrary gaps, never in the
// same cycle as the read's mem_ack.

interface dcache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_re;
  logic [3:0]        cpu_wbyteen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              stall;

  modport master (
    output cpu_re, cpu_wbyteen, cpu_addr, cpu_wdata,
    input  cpu_rdata, stall
  );

  modport slave (
    input  cpu_re, cpu_wbyteen, cpu_addr, cpu_wdata,
    output cpu_rdata, stall
  );
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byteen,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byteen,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dcache_data_array.sv
// Valid/tag/data storage for a direct-mapped cache.
//
// Ports:
//   clk, reset            : clock; async active-high reset clears valid only
//   rd_index, rd_woff     : combinational read port address
//   rd_valid, rd_tag,
//   rd_word               : line valid bit, line tag, addressed word
//   bw_en, bw_index,
//   bw_woff, bw_byteen,
//   bw_data               : byte-enabled word write (store hit)
//   rf_en, rf_index,
//   rf_woff, rf_data      : whole-word write of one refill beat
//   fill_done, fill_tag   : on the last beat, set the line tag and valid
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DC_INDEX_BITS,
  parameter int WOFF_BITS  = DC_WOFF_BITS,
  parameter int TAG_BITS   = TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [WOFF_BITS-1:0]  rd_woff,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_word,
  input  logic                  bw_en,
  input  logic [INDEX_BITS-1:0] bw_index,
  input  logic [WOFF_BITS-1:0]  bw_woff,
  input  logic [3:0]            bw_byteen,
  input  logic [31:0]           bw_data,
  input  logic                  rf_en,
  input  logic [INDEX_BITS-1:0] rf_index,
  input  logic [WOFF_BITS-1:0]  rf_woff,
  input  logic [31:0]           rf_data,
  input  logic                  fill_done,
  input  logic [TAG_BITS-1:0]   fill_tag
);

  localparam int NLINES = 1 << INDEX_BITS;
  localparam int NWORDS = 1 << WOFF_BITS;

  logic [NLINES-1:0]   valid_q;
  logic [TAG_BITS-1:0] tag_mem  [NLINES];
  logic [31:0]         data_mem [NLINES][NWORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[rd_index][rd_woff];

  // Only valid bits are reset. A refill cut short by reset never reaches
  // fill_done, so its line stays invalid whatever the data words hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[rf_index] <= 1'b1;
    end
  end

  // Refill and store writes come from different controller states and are
  // never enabled together.
  always_ff @(posedge clk) begin
    if (rf_en) begin
      data_mem[rf_index][rf_woff] <= rf_data;
    end else if (bw_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bw_byteen[b]) begin
          data_mem[bw_index][bw_woff][8*b +: 8] <= bw_data[8*b +: 8];
        end
      end
    end
    if (fill_done) begin
      tag_mem[rf_index] <= fill_tag;
    end
  end

endmodule

// File: rtl/dcache_stall_ctrl.sv
// Blocking, direct-mapped, write-through, no-write-allocate data cache
// controller between the EX/WB stage and the memory bus. It produces the
// pipeline stall: high while a load miss refills or a store drains.
//
// Ports:
//   clk, reset : clock; asynchronous active-high reset
//   cpu        : pipeline side (load/store request, cpu_rdata, stall)
//   mem        : memory bus side (registered request, ack, refill beats)
//   dbg_state  : current controller state
module dcache_stall_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = DC_ADDR_W,
  parameter int INDEX_BITS = DC_INDEX_BITS,
  parameter int WOFF_BITS  = DC_WOFF_BITS
) (
  input  logic         clk,
  input  logic         reset,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem,
  output state_t       dbg_state
);

  localparam int OFF_LSB  = WOFF_BITS + 2;
  localparam int TAG_LSB  = OFF_LSB + INDEX_BITS;
  localparam int TAG_BITS = ADDR_W - TAG_LSB;

  state_t state, state_n;

  logic [WOFF_BITS-1:0] beat_cnt;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [31:0]          mem_wdata_q;
  logic [3:0]           mem_byteen_q;

  logic                  is_store;
  logic                  is_load;
  logic                  ack_taken;
  logic [ADDR_W-1:0]     lk_addr;
  logic [INDEX_BITS-1:0] lk_index;
  logic [WOFF_BITS-1:0]  lk_woff;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_word;
  logic                  hit;
  logic                  bw_en;
  logic                  rf_en;
  logic                  fill_done;
  logic                  stall_c;
  logic [31:0]           rdata_c;
  logic                  unused_lk_lsbs;

  // A nonzero byte enable makes the request a store even if cpu_re is set.
  assign is_store  = |cpu.cpu_wbyteen;
  assign is_load   = cpu.cpu_re & ~is_store;
  assign ack_taken = mem_req_q & mem.mem_ack;

  // The array lookup serves the pipeline in IDLE and the latched store
  // address in WREQ, where it decides whether the write also updates the
  // cached copy.
  assign lk_addr  = (state == WREQ) ? mem_addr_q : cpu.cpu_addr;
  assign lk_woff  = lk_addr[OFF_LSB-1:2];
  assign lk_index = lk_addr[TAG_LSB-1:OFF_LSB];
  assign lk_tag   = lk_addr[ADDR_W-1:TAG_LSB];
  assign hit      = rd_valid && (rd_tag == lk_tag);

  assign unused_lk_lsbs = ^lk_addr[1:0];

  dcache_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .WOFF_BITS  (WOFF_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (lk_index),
    .rd_woff   (lk_woff),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .bw_en     (bw_en),
    .bw_index  (mem_addr_q[TAG_LSB-1:OFF_LSB]),
    .bw_woff   (mem_addr_q[OFF_LSB-1:2]),
    .bw_byteen (mem_byteen_q),
    .bw_data   (mem_wdata_q),
    .rf_en     (rf_en),
    .rf_index  (mem_addr_q[TAG_LSB-1:OFF_LSB]),
    .rf_woff   (beat_cnt),
    .rf_data   (mem.mem_rdata),
    .fill_done (fill_done),
    .fill_tag  (mem_addr_q[ADDR_W-1:TAG_LSB])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    stall_c   = 1'b0;
    rdata_c   = 32'h0;
    bw_en     = 1'b0;
    rf_en     = 1'b0;
    fill_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_store) begin
          stall_c = 1'b1;
          state_n = WREQ;
        end else if (is_load) begin
          if (hit) begin
            rdata_c = rd_word;
          end else begin
            stall_c = 1'b1;
            state_n = RREQ;
          end
        end
      end
      RREQ: begin
        stall_c = 1'b1;
        if (ack_taken) state_n = RDATA;
      end
      RDATA: begin
        stall_c = 1'b1;
        if (mem.mem_rvalid) begin
          rf_en = 1'b1;
          if (beat_cnt == '1) begin
            fill_done = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      WREQ: begin
        stall_c = 1'b1;
        if (ack_taken) begin
          bw_en   = hit;
          state_n = DONE;
        end
      end
      DONE: begin
        // The retired store is still on the cpu inputs this cycle; the
        // stall is already low, so it is ignored rather than reissued.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus request registers double as the latch for the pending access:
  // mem_addr_q supplies the refill index/tag and the store's address,
  // data and byte enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
      beat_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_store) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= cpu.cpu_addr;
            mem_wdata_q  <= cpu.cpu_wdata;
            mem_byteen_q <= cpu.cpu_wbyteen;
          end else if (is_load && !hit) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {cpu.cpu_addr[ADDR_W-1:OFF_LSB], {OFF_LSB{1'b0}}};
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
          end
        end
        RREQ: begin
          if (ack_taken) begin
            mem_req_q <= 1'b0;
            beat_cnt  <= '0;
          end
        end
        RDATA: begin
          if (mem.mem_rvalid) beat_cnt <= beat_cnt + 1'b1;
        end
        WREQ: begin
          if (ack_taken) mem_req_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cpu.cpu_rdata  = rdata_c;
  assign cpu.stall      = stall_c;
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign mem.mem_byteen = mem_byteen_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl: the bench plays both the pipeline
// and the memory, drives inputs 1 time unit after each rising edge and
// samples outputs 1 time unit later.
module tb_dcache_stall_ctrl;
  import dcache_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  int checks;
  int failures;

  dcache_cpu_if #(.ADDR_W(32)) cpu_bus ();
  dcache_mem_if #(.ADDR_W(32)) mem_bus ();

  dcache_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_bus),
    .mem       (mem_bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_bus.cpu_re      = 1'b0;
    cpu_bus.cpu_wbyteen = 4'h0;
    cpu_bus.cpu_addr    = 32'h0;
    cpu_bus.cpu_wdata   = 32'h0;
    mem_bus.mem_ack     = 1'b0;
    mem_bus.mem_rvalid  = 1'b0;
    mem_bus.mem_rdata   = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  // Load that must miss: counts stall cycles, answers the read request after
  // ack_dly idle cycles, then returns base+0..base+3 with 'gap' idle cycles
  // between beats 1 and 2. Expected stall = 2 + ack_dly + 4 + gap.
  task automatic load_miss(input string tag, input logic [31:0] addr,
                           input logic [31:0] base, input int ack_dly, input int gap);
    int n;
    n = 0;
    cpu_bus.cpu_re      = 1'b1;
    cpu_bus.cpu_wbyteen = 4'h0;
    cpu_bus.cpu_addr    = addr;
    #1;
    chk({tag, "_idle_stall"}, 32'(cpu_bus.stall), 32'd1);
    if (cpu_bus.stall) n++;
    tick();
    chk({tag, "_rreq_state"}, 32'(dbg_state), 32'(RREQ));
    chk({tag, "_rreq_req"}, 32'(mem_bus.mem_req), 32'd1);
    chk({tag, "_rreq_we"}, 32'(mem_bus.mem_we), 32'd0);
    chk({tag, "_rreq_addr"}, mem_bus.mem_addr, addr & 32'hFFFF_FFF0);
    chk({tag, "_rreq_rdata"}, cpu_bus.cpu_rdata, 32'h0);
    for (int i = 0; i < ack_dly; i++) begin
      if (cpu_bus.stall) n++;
      tick();
    end
    mem_bus.mem_ack = 1'b1;
    #1;
    if (cpu_bus.stall) n++;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk({tag, "_req_dropped"}, 32'(mem_bus.mem_req), 32'd0);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        for (int g = 0; g < gap; g++) begin
          if (cpu_bus.stall) n++;
          tick();
        end
      end
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = base + 32'(b);
      #1;
      if (cpu_bus.stall) n++;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'h0;
    end
    #1;
    chk({tag, "_after_stall"}, 32'(cpu_bus.stall), 32'd0);
    chk({tag, "_after_rdata"}, cpu_bus.cpu_rdata, base);
    chk({tag, "_stall_cycles"}, 32'(n), 32'(2 + ack_dly + 4 + gap));
    tick();
    cpu_bus.cpu_re = 1'b0;
  endtask

  task automatic load_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cpu_bus.cpu_re      = 1'b1;
    cpu_bus.cpu_wbyteen = 4'h0;
    cpu_bus.cpu_addr    = addr;
    #1;
    chk({tag, "_stall"}, 32'(cpu_bus.stall), 32'd0);
    chk({tag, "_rdata"}, cpu_bus.cpu_rdata, exp);
    tick();
    cpu_bus.cpu_re = 1'b0;
  endtask

  // Store with immediate ack; re_too also raises cpu_re to show the store
  // takes priority.
  task automatic store_op(input string tag, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic re_too);
    cpu_bus.cpu_re      = re_too;
    cpu_bus.cpu_wbyteen = be;
    cpu_bus.cpu_addr    = addr;
    cpu_bus.cpu_wdata   = data;
    #1;
    chk({tag, "_idle_stall"}, 32'(cpu_bus.stall), 32'd1);
    chk({tag, "_idle_rdata"}, cpu_bus.cpu_rdata, 32'h0);
    tick();
    chk({tag, "_wreq_state"}, 32'(dbg_state), 32'(WREQ));
    chk({tag, "_wreq_req"}, 32'(mem_bus.mem_req), 32'd1);
    chk({tag, "_wreq_we"}, 32'(mem_bus.mem_we), 32'd1);
    chk({tag, "_wreq_addr"}, mem_bus.mem_addr, addr);
    chk({tag, "_wreq_wdata"}, mem_bus.mem_wdata, data);
    chk({tag, "_wreq_byteen"}, 32'(mem_bus.mem_byteen), 32'(be));
    chk({tag, "_wreq_stall"}, 32'(cpu_bus.stall), 32'd1);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    // The store is still presented here and must be ignored.
    chk({tag, "_done_state"}, 32'(dbg_state), 32'(DONE));
    chk({tag, "_done_stall"}, 32'(cpu_bus.stall), 32'd0);
    chk({tag, "_done_req"}, 32'(mem_bus.mem_req), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk({tag, "_back_idle"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_no_reissue"}, 32'(mem_bus.mem_req), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    tick();
    tick();
    // Reset state, sampled while reset is still asserted.
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_stall", 32'(cpu_bus.stall), 32'd0);
    chk("rst_rdata", cpu_bus.cpu_rdata, 32'h0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
    chk("rst_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'h0);
    chk("rst_byteen", 32'(mem_bus.mem_byteen), 32'd0);
    reset = 1'b0;
    tick();

    // Basic refill and hits within the line.
    load_miss("fill1000", 32'h0000_1000, 32'h0000_00A0, 0, 0);
    load_hit("hit100c", 32'h0000_100C, 32'h0000_00A3);
    load_hit("hit1008", 32'h0000_1008, 32'h0000_00A2);

    // Store hits merge under byte enables.
    store_op("st1004", 32'h0000_1004, 4'b0011, 32'h0000_BEEF, 1'b0);
    load_hit("ld1004", 32'h0000_1004, 32'h0000_BEEF);
    store_op("st1008", 32'h0000_1008, 4'b1100, 32'h1234_0000, 1'b0);
    load_hit("ld1008", 32'h0000_1008, 32'h1234_00A2);
    load_hit("ld1000", 32'h0000_1000, 32'h0000_00A0);

    // Store miss with cpu_re also high: write-through only, no allocate.
    store_op("st2000", 32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 1'b1);
    load_miss("ld2000", 32'h0000_2000, 32'hCAFE_F00D, 0, 0);

    // Conflict misses on index 0, starting from a clean cache.
    apply_reset();
    load_miss("cf1000a", 32'h0000_1000, 32'h0000_00C0, 0, 0);
    load_miss("cf1100", 32'h0000_1100, 32'h0000_00D0, 0, 0);
    load_miss("cf1000b", 32'h0000_1000, 32'h0000_00E0, 0, 0);
    load_hit("cf100c", 32'h0000_100C, 32'h0000_00E3);

    // Delayed ack and a gap between beats 1 and 2.
    load_miss("slow2040", 32'h0000_2040, 32'h0000_5550, 3, 2);
    load_hit("slow2044", 32'h0000_2044, 32'h0000_5551);
    load_hit("slow2048", 32'h0000_2048, 32'h0000_5552);
    load_hit("slow204c", 32'h0000_204C, 32'h0000_5553);

    // Reset arriving during beat 2 of a refill.
    cpu_bus.cpu_re   = 1'b1;
    cpu_bus.cpu_addr = 32'h0000_3000;
    tick();
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'h0000_00F0 + 32'(b);
      tick();
    end
    chk("midrst_pre_state", 32'(dbg_state), 32'(RDATA));
    mem_bus.mem_rdata = 32'h0000_00F2;
    cpu_bus.cpu_re    = 1'b0;
    reset             = 1'b1;
    #1;
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("midrst_stall", 32'(cpu_bus.stall), 32'd0);
    chk("midrst_rdata", cpu_bus.cpu_rdata, 32'h0);
    tick();
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    reset              = 1'b0;
    tick();
    load_miss("refill3000", 32'h0000_3000, 32'h0000_0F00, 0, 0);
    // Earlier lines were invalidated by the reset as well.
    load_miss("post_rst2040", 32'h0000_2040, 32'h0000_7770, 0, 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
